conv_window_sched: RTL and testbench

- Sequencer that drives one conv_calc instance across a full input feature map: 5x5 window, stride 1, no padding.
- Fetches each window's pixels from an external single-port feature-map RAM (1-cycle read latency) and packs them into the conv_calc data_in layout.
- Presents each window with a valid/ready handshake, then advances the window position until the whole output map is covered.
- Sits between the feature-map RAM and conv_calc; its win_val drives conv_calc in_val.

---
 rtl/conv_window_sched_if.sv | 38 +++
 rtl/conv_window_sched.sv | 143 ++++++++++++++
 tb/tb_conv_window_sched.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_sched_if.sv
// Feature-map RAM read port and window output handshake
// shared by conv_window_sched and its neighbours.
interface conv_window_sched_if #(
    parameter int FILTER_SIZE = 5,
    parameter int DATA_BITS   = 8,
    parameter int IMG_W       = 32,
    parameter int IMG_H       = 32,
    parameter int ADDR_BITS   = 10
);
    localparam int ROW_BITS = $clog2(IMG_H - FILTER_SIZE + 1);
    localparam int COL_BITS = $clog2(IMG_W - FILTER_SIZE + 1);
    localparam int WIN_BITS = FILTER_SIZE * FILTER_SIZE * DATA_BITS;

    logic                 mem_rd;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_data;
    logic [WIN_BITS-1:0]  win_data;
    logic                 win_val;
    logic                 out_ready;
    logic [ROW_BITS-1:0]  out_row;
    logic [COL_BITS-1:0]  out_col;

    modport master (
        output mem_rd, mem_addr,
        input  mem_data,
        output win_data, win_val,
        input  out_ready,
        output out_row, out_col
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_data,
        input  win_data, win_val,
        output out_ready,
        input  out_row, out_col
    );
endinterface

// File: rtl/conv_window_sched.sv
// Walks a FSxFS stride-1 window over the input map, fetching each
// window from a 1-cycle-latency RAM and presenting it to conv_calc.
module conv_window_sched #(
    parameter int FILTER_SIZE = 5,
    parameter int DATA_BITS   = 8,
    parameter int IMG_W       = 32,
    parameter int IMG_H       = 32,
    parameter int ADDR_BITS   = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    conv_window_sched_if.master bus
);
    localparam int FS    = FILTER_SIZE;
    localparam int NPIX  = FS * FS;
    localparam int OUT_W = IMG_W - FS + 1;
    localparam int OUT_H = IMG_H - FS + 1;
    localparam int RW    = $clog2(OUT_H);
    localparam int CW    = $clog2(OUT_W);
    localparam int KW    = $clog2(NPIX);
    localparam int FW    = $clog2(FS);
    localparam int WB    = NPIX * DATA_BITS;

    typedef enum logic [2:0] {
        IDLE, FETCH, DRAIN, PRESENT, DONE
    } state_t;

    state_t state_q, state_d;

    logic [KW-1:0] k_q;
    logic [FW-1:0] kx_q, ky_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic          cap_q;
    logic [KW-1:0] cap_k_q;
    logic [WB-1:0] win_q;

    logic mem_rd, win_val, last_k, last_win, accept;

    assign last_k   = (k_q == KW'(NPIX - 1));
    assign last_win = (row_q == RW'(OUT_H - 1)) &&
                      (col_q == CW'(OUT_W - 1));
    assign accept   = (state_q == PRESENT) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        mem_rd  = 1'b0;
        win_val = 1'b0;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        unique case (state_q)
            IDLE: begin
                if (start)
                    state_d = FETCH;
            end
            FETCH: begin
                mem_rd = 1'b1;
                if (last_k)
                    state_d = DRAIN;
            end
            DRAIN: state_d = PRESENT;
            PRESENT: begin
                win_val = 1'b1;
                if (bus.out_ready)
                    state_d = last_win ? DONE : FETCH;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Window offset kept as (ky,kx) so the address needs no div/mod
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q  <= '0;
            kx_q <= '0;
            ky_q <= '0;
        end else if (state_q == FETCH) begin
            if (last_k) begin
                k_q  <= '0;
                kx_q <= '0;
                ky_q <= '0;
            end else begin
                k_q <= k_q + 1'b1;
                if (kx_q == FW'(FS - 1)) begin
                    kx_q <= '0;
                    ky_q <= ky_q + 1'b1;
                end else begin
                    kx_q <= kx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            if (last_win) begin
                row_q <= '0;
                col_q <= '0;
            end else if (col_q == CW'(OUT_W - 1)) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Read data lands one cycle after the strobe; remember which slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q   <= 1'b0;
            cap_k_q <= '0;
            win_q   <= '0;
        end else begin
            cap_q   <= mem_rd;
            cap_k_q <= k_q;
            if (cap_q)
                win_q[cap_k_q*DATA_BITS +: DATA_BITS] <= bus.mem_data;
        end
    end

    assign bus.mem_rd   = mem_rd;
    assign bus.mem_addr = ADDR_BITS'(
        (32'(row_q) + 32'(ky_q)) * IMG_W + 32'(col_q) + 32'(kx_q));
    assign bus.win_data = win_q;
    assign bus.win_val  = win_val;
    assign bus.out_row  = row_q;
    assign bus.out_col  = col_q;
endmodule

// File: tb/tb_conv_window_sched.sv
// Scoreboard bench for conv_window_sched: random RAM contents and
// backpressure against a window-level reference model.
module tb_conv_window_sched;
    localparam int FS    = 5;
    localparam int DB    = 8;
    localparam int IW    = 32;
    localparam int IH    = 32;
    localparam int AB    = 10;
    localparam int OW    = IW - FS + 1;
    localparam int OH    = IH - FS + 1;
    localparam int NWIN  = OW * OH;
    localparam int DONE_CYC = 27 * NWIN + 1;

    typedef struct {
        int         row;
        int         col;
        logic [199:0] data;
    } win_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy, done;

    conv_window_sched_if #(
        .FILTER_SIZE(FS), .DATA_BITS(DB), .IMG_W(IW),
        .IMG_H(IH), .ADDR_BITS(AB)
    ) bus ();

    conv_window_sched #(
        .FILTER_SIZE(FS), .DATA_BITS(DB), .IMG_W(IW),
        .IMG_H(IH), .ADDR_BITS(AB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [1024];
    win_t sb[$];
    int checks = 0;
    int errors = 0;
    int edges = 0;
    int s0 = 0;
    int pass_id = 0;
    int passes = 0;
    int acc = 0;
    int stalls = 0;
    int mode = 0;

    always @(posedge clk) edges <= edges + 1;

    always @(posedge clk)
        if (bus.mem_rd) bus.mem_data <= ram[bus.mem_addr];

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_busy"}, 256'(busy), 0);
        chk({tag, "_done"}, 256'(done), 0);
        chk({tag, "_mem_rd"}, 256'(bus.mem_rd), 0);
        chk({tag, "_mem_addr"}, 256'(bus.mem_addr), 0);
        chk({tag, "_win_data"}, 256'(bus.win_data), 0);
        chk({tag, "_win_val"}, 256'(bus.win_val), 0);
        chk({tag, "_out_row"}, 256'(bus.out_row), 0);
        chk({tag, "_out_col"}, 256'(bus.out_col), 0);
    endtask

    // Reference: every window in raster order, pixels row-major
    task automatic push_pass();
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++) begin
                win_t w;
                w.row = r;
                w.col = c;
                w.data = '0;
                for (int k = 0; k < FS * FS; k++)
                    w.data[k*DB +: DB] = ram[(r + k / FS) * IW + c + k % FS];
                sb.push_back(w);
            end
    endtask

    task automatic do_start();
        @(negedge clk);
        push_pass();
        s0 = edges + 1;
        pass_id++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_pass(string name, int budget);
        int n0;
        int i;
        n0 = passes;
        for (i = 0; i < budget && passes == n0; i++) @(negedge clk);
        chk({name, "_timeout"}, 256'(passes == n0), 0);
    endtask

    // Backpressure driver: window 3 of a random pass is held 10 cycles
    initial begin
        int held;
        int my_pass;
        held = 0;
        my_pass = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (pass_id != my_pass) begin
                my_pass = pass_id;
                held = 0;
            end
            if (mode == 1 && bus.win_val && acc == 3 && held < 10) begin
                bus.out_ready = 1'b0;
                held++;
            end else if (mode == 1) begin
                bus.out_ready = ($urandom_range(3) != 0);
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    // Monitor
    initial begin
        int my_pass;
        logic prev_stall;
        logic busy_next;
        logic [199:0] pdata;
        int prow, pcol, cyc;
        win_t e;
        my_pass = 0;
        prev_stall = 0;
        busy_next = 0;
        pdata = '0;
        prow = 0;
        pcol = 0;
        forever begin
            @(negedge clk);
            if (pass_id != my_pass) begin
                my_pass = pass_id;
                acc = 0;
                stalls = 0;
            end
            cyc = edges + 1 - s0;
            if (!rst_n) begin
                prev_stall = 0;
                busy_next = 0;
            end else begin
                if (busy_next) chk("busy_after_done", 256'(busy), 0);
                busy_next = 0;
                if (bus.win_val && prev_stall) begin
                    chk("stall_data", 256'(bus.win_data), 256'(pdata));
                    chk("stall_row", 256'(bus.out_row), 256'(prow));
                    chk("stall_col", 256'(bus.out_col), 256'(pcol));
                end
                if (bus.win_val && !bus.out_ready) begin
                    chk("stall_mem_rd", 256'(bus.mem_rd), 0);
                    stalls++;
                    prev_stall = 1;
                    pdata = bus.win_data;
                    prow = int'(bus.out_row);
                    pcol = int'(bus.out_col);
                end else begin
                    prev_stall = 0;
                end
                if (bus.win_val && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_window", 256'(1), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("win_row", 256'(bus.out_row), 256'(e.row));
                        chk("win_col", 256'(bus.out_col), 256'(e.col));
                        chk("win_data", 256'(bus.win_data), 256'(e.data));
                        chk("win_cycle", 256'(cyc),
                            256'(27 * (acc + 1) + stalls));
                        acc++;
                    end
                end
                if (done) begin
                    chk("done_windows", 256'(acc), 256'(NWIN));
                    chk("done_sb_empty", 256'(sb.size()), 0);
                    chk("done_cycle", 256'(cyc), 256'(DONE_CYC + stalls));
                    busy_next = 1;
                    passes++;
                end
            end
        end
    end

    initial begin
        int i;
        rst_n = 1'b0;
        start = 1'b0;
        bus.mem_data = '0;
        for (int a = 0; a < 1024; a++) ram[a] = 8'(a);
        #2;
        chk_reset("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("idle");

        // Pass A: ramp RAM, no backpressure, stray starts while busy
        mode = 0;
        do_start();
        repeat (100) @(negedge clk);
        pulse_start();
        repeat (3000) @(negedge clk);
        pulse_start();
        for (i = 0; i < 30000 && !done; i++) @(negedge clk);
        chk("passA_timeout", 256'(done), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("passA_restart_busy", 256'(busy), 0);
        chk("passA_count", 256'(passes), 1);

        // Pass B: random RAM with random backpressure
        for (int a = 0; a < 1024; a++) ram[a] = 8'($urandom);
        mode = 1;
        do_start();
        wait_pass("passB", 40000);
        mode = 0;
        repeat (5) @(negedge clk);

        // Pass C: reset during FETCH of window 5
        do_start();
        for (i = 0; i < 2000 && acc < 5; i++) @(negedge clk);
        chk("passC_reach5", 256'(acc), 5);
        repeat (6) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("abort");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk_reset("post_abort");

        // Pass D: clean pass after the abort
        for (int a = 0; a < 1024; a++) ram[a] = 8'($urandom);
        do_start();
        wait_pass("passD", 30000);
        repeat (5) @(negedge clk);
        chk("total_passes", 256'(passes), 3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
